compressor_top: RTL and testbench

// Streaming LZRW1 compressor: the encoder counterpart of decompressor_top.

---
 rtl/compressor_top.sv | 197 +++++++++++++++++++
 tb/tb_compressor_top.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compressor_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | compressor_top                                                           |
// | Streaming LZRW1 compressor: bytes in, 16-bit literal/copy items out.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module compressor_top #(
    parameter int HISTORY_SIZE = 256,
    parameter int HASH_ENTRIES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_in_valid,
    input  logic        end_of_input,
    output logic [15:0] compressed_word,
    output logic        control_bit,
    output logic        out_valid,
    output logic        compressor_busy,
    output logic        done
);
    localparam int          c_AW      = $clog2(HISTORY_SIZE);
    localparam int          c_HW      = $clog2(HASH_ENTRIES);
    localparam logic [15:0] c_MAX_OFF = 16'(HISTORY_SIZE - 18);

    typedef enum logic [2:0] {
        S_FILL, S_LOOKUP, S_VERIFY, S_EXTEND,
        S_EMIT_COPY, S_EMIT_LIT, S_FLUSH, S_DONE
    } state_t;

    state_t             r_state;
    logic [15:0]        r_pos;
    logic [7:0]         r_pend [0:2];
    logic [1:0]         r_cnt;
    logic [c_AW-1:0]    r_cand_a;
    logic [11:0]        r_off;
    logic [4:0]         r_len;
    logic [HASH_ENTRIES-1:0] r_ht_vld;
    logic [15:0]        r_ht_pos [HASH_ENTRIES];
    logic [7:0]         r_hist [HISTORY_SIZE];
    logic [15:0]        r_word;
    logic               r_ctrl;
    logic               r_ov;
    logic               r_done;

    logic               w_accept;
    logic [15:0]        w_item_start;
    logic [c_HW-1:0]    w_hash;
    logic [15:0]        w_ht_cand;
    logic [15:0]        w_off;
    logic               w_hit;
    logic               w_ver_eq;
    logic [c_AW-1:0]    w_ext_addr;
    logic               w_ext_eq;

    function automatic logic [15:0] f_copy(input logic [4:0] len, input logic [11:0] off);
        f_copy = {4'(len - 5'd3), off};
    endfunction

    assign compressor_busy = !(r_state == S_FILL || r_state == S_EXTEND);
    assign w_accept        = data_in_valid && !compressor_busy;
    assign w_item_start    = r_pos - {14'd0, r_cnt};

    assign w_hash    = c_HW'(({4'h0, r_pend[0]} << 4) ^ ({4'h0, r_pend[1]} << 2) ^ {4'h0, r_pend[2]});
    assign w_ht_cand = r_ht_pos[w_hash];
    assign w_off     = w_item_start - w_ht_cand;
    // Offsets beyond HISTORY_SIZE-18 could reach bytes overwritten during an 18-byte copy.
    assign w_hit     = r_ht_vld[w_hash] && (w_off != 16'd0) && (w_off <= c_MAX_OFF);

    assign w_ver_eq  = (r_hist[r_cand_a]             == r_pend[0]) &&
                       (r_hist[r_cand_a + c_AW'(1)]  == r_pend[1]) &&
                       (r_hist[r_cand_a + c_AW'(2)]  == r_pend[2]);
    assign w_ext_addr = r_cand_a + c_AW'(r_len);
    assign w_ext_eq   = (r_hist[w_ext_addr] == data_in);

    assign compressed_word = r_word;
    assign control_bit     = r_ctrl;
    assign out_valid       = r_ov;
    assign done            = r_done;

    // History and hash positions carry no meaning until a valid hash entry points at them.
    always_ff @(posedge clock) begin
        if (w_accept)
            r_hist[r_pos[c_AW-1:0]] <= data_in;
        if (r_state == S_LOOKUP)
            r_ht_pos[w_hash] <= w_item_start;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_FILL;
            r_pos    <= 16'd0;
            r_pend   <= '{default: 8'h00};
            r_cnt    <= 2'd0;
            r_cand_a <= '0;
            r_off    <= 12'd0;
            r_len    <= 5'd0;
            r_ht_vld <= '0;
            r_word   <= 16'd0;
            r_ctrl   <= 1'b0;
            r_ov     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ov <= 1'b0;
            if (w_accept)
                r_pos <= r_pos + 16'd1;
            case (r_state)
                S_FILL: begin
                    if (data_in_valid) begin
                        r_pend[r_cnt] <= data_in;
                        r_cnt         <= r_cnt + 2'd1;
                        if (r_cnt == 2'd2)
                            r_state <= S_LOOKUP;
                    end else if (end_of_input) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_LOOKUP: begin
                    r_ht_vld[w_hash] <= 1'b1;
                    if (w_hit) begin
                        r_cand_a <= w_ht_cand[c_AW-1:0];
                        r_off    <= w_off[11:0];
                        r_state  <= S_VERIFY;
                    end else begin
                        r_word  <= {8'h00, r_pend[0]};
                        r_ctrl  <= 1'b0;
                        r_ov    <= 1'b1;
                        r_state <= S_EMIT_LIT;
                    end
                end
                S_VERIFY: begin
                    if (w_ver_eq) begin
                        r_len   <= 5'd3;
                        r_cnt   <= 2'd0;
                        r_state <= S_EXTEND;
                    end else begin
                        r_word  <= {8'h00, r_pend[0]};
                        r_ctrl  <= 1'b0;
                        r_ov    <= 1'b1;
                        r_state <= S_EMIT_LIT;
                    end
                end
                S_EXTEND: begin
                    if (data_in_valid) begin
                        if (w_ext_eq) begin
                            r_len <= r_len + 5'd1;
                            if (r_len == 5'd17) begin
                                r_word  <= f_copy(5'd18, r_off);
                                r_ctrl  <= 1'b1;
                                r_ov    <= 1'b1;
                                r_state <= S_EMIT_COPY;
                            end
                        end else begin
                            r_word    <= f_copy(r_len, r_off);
                            r_ctrl    <= 1'b1;
                            r_ov      <= 1'b1;
                            r_pend[0] <= data_in;
                            r_cnt     <= 2'd1;
                            r_state   <= S_EMIT_COPY;
                        end
                    end else if (end_of_input) begin
                        r_word  <= f_copy(r_len, r_off);
                        r_ctrl  <= 1'b1;
                        r_ov    <= 1'b1;
                        r_state <= S_EMIT_COPY;
                    end
                end
                S_EMIT_COPY: begin
                    r_state <= S_FILL;
                end
                S_EMIT_LIT: begin
                    r_pend[0] <= r_pend[1];
                    r_pend[1] <= r_pend[2];
                    r_cnt     <= 2'd2;
                    r_state   <= S_FILL;
                end
                S_FLUSH: begin
                    if (r_cnt != 2'd0) begin
                        r_word    <= {8'h00, r_pend[0]};
                        r_ctrl    <= 1'b0;
                        r_ov      <= 1'b1;
                        r_pend[0] <= r_pend[1];
                        r_pend[1] <= r_pend[2];
                        r_cnt     <= r_cnt - 2'd1;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_DONE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_compressor_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_compressor_top                                                        |
// | Scoreboard bench for compressor_top (HISTORY_SIZE 256 and 32 instances). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_compressor_top;
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst  [2];
    logic [7:0]  din  [2];
    logic        vld  [2];
    logic        eoi  [2];
    logic [15:0] word [2];
    logic        ctl  [2];
    logic        ov   [2];
    logic        busy [2];
    logic        dn   [2];

    compressor_top #(.HISTORY_SIZE(256), .HASH_ENTRIES(256)) u_dut0 (
        .clock(clock), .reset(rst[0]), .data_in(din[0]), .data_in_valid(vld[0]),
        .end_of_input(eoi[0]), .compressed_word(word[0]), .control_bit(ctl[0]),
        .out_valid(ov[0]), .compressor_busy(busy[0]), .done(dn[0]));

    compressor_top #(.HISTORY_SIZE(32), .HASH_ENTRIES(256)) u_dut1 (
        .clock(clock), .reset(rst[1]), .data_in(din[1]), .data_in_valid(vld[1]),
        .end_of_input(eoi[1]), .compressed_word(word[1]), .control_bit(ctl[1]),
        .out_valid(ov[1]), .compressor_busy(busy[1]), .done(dn[1]));

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  stim [$];
    logic [16:0] exp0 [$], exp1 [$];
    logic [16:0] obs0 [$], obs1 [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int d, input logic [16:0] v);
        if (d == 0) exp0.push_back(v);
        else        exp1.push_back(v);
    endtask

    task automatic mon(input int d, input logic [16:0] got);
        logic [16:0] e;
        int          n;
        n = (d == 0) ? exp0.size() : exp1.size();
        checks++;
        if (d == 0) obs0.push_back(got);
        else        obs1.push_back(got);
        if (n == 0) begin
            errors++;
            $display("FAIL item%0d: unexpected item %05h, none expected", d, got);
        end else begin
            e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL item%0d: got %05h expected %05h", d, got, e);
            end
        end
    endtask

    always @(negedge clock) begin
        if (ov[0]) mon(0, {ctl[0], word[0]});
        if (ov[1]) mon(1, {ctl[1], word[1]});
    end

    // Reference LZRW1 over the whole stream; positions count from reset.
    task automatic model(input int d, input int hsz);
        bit hv [256];
        int hp [256];
        int n, i, h, cand, off, len;
        bit hit;
        n = stim.size();
        i = 0;
        for (int k = 0; k < 256; k++) begin hv[k] = 0; hp[k] = 0; end
        while (n - i >= 3) begin
            h = ((int'(stim[i]) << 4) ^ (int'(stim[i+1]) << 2) ^ int'(stim[i+2])) & 255;
            cand = hp[h];
            off  = (i - cand) & 16'hFFFF;
            hit  = hv[h] && off >= 1 && off <= hsz - 18;
            hv[h] = 1;
            hp[h] = i;
            if (hit && stim[cand] == stim[i] && stim[cand+1] == stim[i+1] && stim[cand+2] == stim[i+2]) begin
                len = 3;
                while (len < 18 && i + len < n && stim[i+len] == stim[cand+len]) len++;
                push(d, {1'b1, 4'(len - 3), 12'(off)});
                i += len;
            end else begin
                push(d, {9'h000, stim[i]});
                i++;
            end
        end
        while (i < n) begin
            push(d, {9'h000, stim[i]});
            i++;
        end
    endtask

    task automatic set_str(input string s);
        stim.delete();
        for (int k = 0; k < s.len(); k++) stim.push_back(s[k]);
    endtask

    task automatic gen_random(input int maxlen, input int alpha);
        int n;
        stim.delete();
        n = $urandom_range(0, maxlen);
        for (int k = 0; k < n; k++) stim.push_back(8'h61 + 8'($urandom_range(0, alpha - 1)));
    endtask

    task automatic feed(input int d, input bit hold);
        int guard;
        for (int k = 0; k < stim.size(); k++) begin
            if (!hold && $urandom_range(0, 3) == 0) begin
                vld[d] = 1'b0;
                @(posedge clock); #1;
            end
            din[d] = stim[k];
            vld[d] = 1'b1;
            guard  = 0;
            while (busy[d] && guard < 100) begin
                @(posedge clock); #1;
                guard++;
            end
            if (guard >= 100) chk("accept_timeout", busy[d], 0);
            @(posedge clock); #1;
        end
        vld[d] = 1'b0;
    endtask

    task automatic chk_decode(input int d);
        logic [16:0] it;
        logic [7:0]  dec [$];
        int          n, off, len;
        bit          ok;
        ok = 1;
        n  = (d == 0) ? obs0.size() : obs1.size();
        for (int k = 0; k < n; k++) begin
            it = (d == 0) ? obs0[k] : obs1[k];
            if (!it[16]) dec.push_back(it[7:0]);
            else begin
                off = int'(it[11:0]);
                len = int'(it[15:12]) + 3;
                for (int j = 0; j < len; j++) begin
                    if (off < 1 || off > dec.size()) ok = 0;
                    else dec.push_back(dec[dec.size() - off]);
                end
            end
        end
        chk("decode_len", dec.size(), stim.size());
        if (dec.size() == stim.size())
            for (int k = 0; k < stim.size(); k++) if (dec[k] !== stim[k]) ok = 0;
        chk("decode_data", {31'd0, ok}, 1);
    endtask

    task automatic finish_stream(input int d, output int cyc);
        vld[d] = 1'b0;
        eoi[d] = 1'b1;
        cyc    = 0;
        while (!dn[d] && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("done", dn[d], 1);
        chk("busy_in_done", busy[d], 1);
        chk("drained", (d == 0) ? exp0.size() : exp1.size(), 0);
        chk_decode(d);
        #2 rst[d] = 1'b1;
        #1;
        chk("rst_async_ov", ov[d], 0);
        chk("rst_async_busy", busy[d], 0);
        chk("rst_async_done", dn[d], 0);
        @(posedge clock); #1;
        rst[d] = 1'b0;
        eoi[d] = 1'b0;
        if (d == 0) begin obs0.delete(); exp0.delete(); end
        else        begin obs1.delete(); exp1.delete(); end
    endtask

    task automatic run_model(input int d, input int hsz, input bit hold);
        int cyc;
        model(d, hsz);
        feed(d, hold);
        finish_stream(d, cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; din[d] = 8'h00; vld[d] = 1'b0; eoi[d] = 1'b0;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ov", ov[d], 0);
            chk("reset_busy", busy[d], 0);
            chk("reset_done", dn[d], 0);
            chk("reset_word", word[d], 0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        set_str("abcabcabc");
        push(0, 17'h00061); push(0, 17'h00062); push(0, 17'h00063); push(0, 17'h13003);
        feed(0, 0);
        finish_stream(0, cyc);

        stim.delete();
        for (int k = 0; k < 20; k++) stim.push_back(8'h61);
        push(0, 17'h00061); push(0, 17'h1F001); push(0, 17'h00061);
        feed(0, 1);
        finish_stream(0, cyc);

        set_str("xy");
        push(0, 17'h00078); push(0, 17'h00079);
        feed(0, 0);
        finish_stream(0, cyc);

        stim.delete();
        finish_stream(0, cyc);
        chk("empty_done_cycles_le2", (cyc <= 2), 1);

        // Park the engine mid-match, then reset and restart.
        set_str("abcabc");
        push(0, 17'h00061); push(0, 17'h00062); push(0, 17'h00063);
        feed(0, 1);
        repeat (6) @(posedge clock);
        #1;
        chk("extend_prefix_drained", exp0.size(), 0);
        #2 rst[0] = 1'b1;
        #1;
        chk("rst_extend_ov", ov[0], 0);
        chk("rst_extend_busy", busy[0], 0);
        chk("rst_extend_done", dn[0], 0);
        @(posedge clock); #1;
        rst[0] = 1'b0;
        obs0.delete();
        set_str("abc");
        push(0, 17'h00061); push(0, 17'h00062); push(0, 17'h00063);
        feed(0, 0);
        finish_stream(0, cyc);

        set_str("abc");
        for (int k = 0; k < 40; k++) stim.push_back(8'h20);
        stim.push_back(8'h61); stim.push_back(8'h62); stim.push_back(8'h63);
        run_model(1, 32, 0);

        for (int t = 0; t < 8; t++) begin
            gen_random(70, (t % 3) + 2);
            run_model(0, 256, t[0]);
        end
        for (int t = 0; t < 6; t++) begin
            gen_random(90, (t % 2) + 2);
            run_model(1, 32, t[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
